// File: rtl/bg_subtract_mc.sv
// Streaming multi-channel background subtractor.
// Pops paired background/new-frame words from two FWFT FIFOs, computes a
// foreground mask pixel and an optional running-average background word
// through a two-stage pipeline, and counts foreground pixels per frame.
module bg_subtract_mc #(
    parameter int PIX_W       = 8,
    parameter int CHANNELS    = 3,
    parameter int FRAME_PIX   = 76800,
    parameter int ALPHA_SHIFT = 3,
    localparam int WORD_W     = CHANNELS * PIX_W,
    localparam int CNT_W      = $clog2(FRAME_PIX + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PIX_W+1:0]    cfg_thresh,
    input  logic                cfg_mode,
    input  logic                cfg_bg_upd,
    input  logic                cfg_select,
    input  logic                bg_empty,
    input  logic [WORD_W-1:0]   bg_data,
    output logic                bg_re,
    input  logic                new_empty,
    input  logic [WORD_W-1:0]   new_data,
    output logic                new_re,
    input  logic                mask_full,
    output logic                mask_we,
    output logic [PIX_W-1:0]    mask_data,
    input  logic                bgo_full,
    output logic                bgo_we,
    output logic [WORD_W-1:0]   bgo_data,
    output logic                frame_done,
    output logic [CNT_W-1:0]    fg_count
);

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIX - 1);

    // Handshake
    logic                out_ok_s;
    logic                s2_load_s;
    logic                s1_load_s;
    logic                pop_s;
    logic                mask_we_s;
    logic                last_pix_s;

    // Stage 1: per-channel |diff|, averaged background, per-pixel config
    logic                s1_valid_q;
    logic [WORD_W-1:0]   s1_diff_q,  s1_diff_d;
    logic [WORD_W-1:0]   s1_avg_q,   s1_avg_d;
    logic [WORD_W-1:0]   s1_bg_q;
    logic [PIX_W+1:0]    s1_thr_q,   s1_thr_d;
    logic                s1_mode_q;
    logic                s1_sel_q;

    // Stage 2: mask bit and outgoing background word
    logic                s2_valid_q;
    logic                s2_fg_q,    s2_fg_d;
    logic [WORD_W-1:0]   s2_bgo_q,   s2_bgo_d;

    // Frame bookkeeping: pop side (threshold latch) and push side (counts)
    logic [PIX_W+1:0]    thr_q;
    logic [CNT_W-1:0]    pop_idx_q;
    logic [CNT_W-1:0]    pix_cnt_q;
    logic [CNT_W-1:0]    fg_acc_q;
    logic [CNT_W-1:0]    fg_count_q;

    // Flow control: both FIFOs pop together and both outputs push together;
    // pops are suppressed while reset is held so no word is lost upstream.
    always_comb begin
        out_ok_s   = !mask_full && (!cfg_bg_upd || !bgo_full);
        s2_load_s  = !s2_valid_q || out_ok_s;
        s1_load_s  = !s1_valid_q || s2_load_s;
        pop_s      = !bg_empty && !new_empty && s1_load_s && !rst;
        mask_we_s  = s2_valid_q && out_ok_s;
        last_pix_s = (pix_cnt_q == LAST_PIX);
    end

    assign bg_re      = pop_s;
    assign new_re     = pop_s;
    assign mask_we    = mask_we_s;
    assign bgo_we     = mask_we_s && cfg_bg_upd;
    assign frame_done = mask_we_s && last_pix_s;
    assign mask_data  = {PIX_W{s2_fg_q}};
    assign bgo_data   = s2_bgo_q;
    assign fg_count   = fg_count_q;

    // Stage-1 datapath: signed difference, its magnitude and the running average.
    always_comb begin : s1_calc
        logic signed [PIX_W:0] diff_s;
        logic signed [PIX_W:0] mag_s;
        logic signed [PIX_W:0] avg_s;
        diff_s    = '0;
        mag_s     = '0;
        avg_s     = '0;
        s1_diff_d = '0;
        s1_avg_d  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            diff_s = $signed({1'b0, new_data[c*PIX_W +: PIX_W]})
                   - $signed({1'b0, bg_data[c*PIX_W +: PIX_W]});
            mag_s  = diff_s[PIX_W] ? -diff_s : diff_s;
            // Moves bg toward new by a fraction, so the result stays in pixel range.
            avg_s  = $signed({1'b0, bg_data[c*PIX_W +: PIX_W]}) + (diff_s >>> ALPHA_SHIFT);
            s1_diff_d[c*PIX_W +: PIX_W] = mag_s[PIX_W-1:0];
            s1_avg_d[c*PIX_W +: PIX_W]  = avg_s[PIX_W-1:0];
        end
        // Pixel 0 of a frame uses the live threshold it is latching.
        s1_thr_d = (pop_idx_q == '0) ? cfg_thresh : thr_q;
    end

    // Stage-2 datapath: foreground decision and choice of outgoing background.
    always_comb begin : s2_calc
        logic [PIX_W+1:0] sum_s;
        logic             any_s;
        sum_s = '0;
        any_s = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            sum_s = sum_s + {2'b00, s1_diff_q[c*PIX_W +: PIX_W]};
            any_s = any_s | ({2'b00, s1_diff_q[c*PIX_W +: PIX_W]} > s1_thr_q);
        end
        s2_fg_d  = s1_mode_q ? (sum_s > s1_thr_q) : any_s;
        s2_bgo_d = (s1_sel_q && s2_fg_d) ? s1_bg_q : s1_avg_q;
    end

    // Pipeline registers; contents only change on a load so stalls hold data steady.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_diff_q  <= '0;
            s1_avg_q   <= '0;
            s1_bg_q    <= '0;
            s1_thr_q   <= '0;
            s1_mode_q  <= 1'b0;
            s1_sel_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_fg_q    <= 1'b0;
            s2_bgo_q   <= '0;
        end else begin
            if (s1_load_s) begin
                s1_valid_q <= pop_s;
                if (pop_s) begin
                    s1_diff_q <= s1_diff_d;
                    s1_avg_q  <= s1_avg_d;
                    s1_bg_q   <= bg_data;
                    s1_thr_q  <= s1_thr_d;
                    s1_mode_q <= cfg_mode;
                    s1_sel_q  <= cfg_select;
                end
            end
            if (s2_load_s) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_fg_q  <= s2_fg_d;
                    s2_bgo_q <= s2_bgo_d;
                end
            end
        end
    end

    // Pop-side frame position; latches the threshold when pixel 0 is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_q     <= '0;
            pop_idx_q <= '0;
        end else if (pop_s) begin
            if (pop_idx_q == '0) begin
                thr_q <= cfg_thresh;
            end
            pop_idx_q <= (pop_idx_q == LAST_PIX) ? '0 : pop_idx_q + CNT_W'(1);
        end
    end

    // Push-side frame position and foreground count, published at end of frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt_q  <= '0;
            fg_acc_q   <= '0;
            fg_count_q <= '0;
        end else if (mask_we_s) begin
            if (last_pix_s) begin
                pix_cnt_q  <= '0;
                fg_acc_q   <= '0;
                fg_count_q <= fg_acc_q + CNT_W'(s2_fg_q);
            end else begin
                pix_cnt_q  <= pix_cnt_q + CNT_W'(1);
                fg_acc_q   <= fg_acc_q + CNT_W'(s2_fg_q);
            end
        end
    end

endmodule

// File: tb/tb_bg_subtract_mc.sv
// Self-checking bench for bg_subtract_mc: queue-based FIFOs around the DUT and
// an arithmetic reference model of mask, averaged background and frame counts.
module tb_bg_subtract_mc;

    localparam int PIX_W = 8;
    localparam int CH    = 3;
    localparam int FP    = 16;
    localparam int AS    = 3;
    localparam int WW    = CH * PIX_W;
    localparam int CW    = $clog2(FP + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [PIX_W+1:0] cfg_thresh = '0;
    logic            cfg_mode = 1'b0, cfg_bg_upd = 1'b0, cfg_select = 1'b0;
    logic            bg_empty = 1'b1, new_empty = 1'b1;
    logic [WW-1:0]   bg_data = '0, new_data = '0;
    logic            bg_re, new_re;
    logic            mask_full = 1'b0, bgo_full = 1'b0;
    logic            mask_we, bgo_we, frame_done;
    logic [PIX_W-1:0] mask_data;
    logic [WW-1:0]   bgo_data;
    logic [CW-1:0]   fg_count;

    always #5 clk = ~clk;

    bg_subtract_mc #(.PIX_W(PIX_W), .CHANNELS(CH), .FRAME_PIX(FP), .ALPHA_SHIFT(AS)) dut (
        .clk(clk), .rst(rst), .cfg_thresh(cfg_thresh), .cfg_mode(cfg_mode),
        .cfg_bg_upd(cfg_bg_upd), .cfg_select(cfg_select),
        .bg_empty(bg_empty), .bg_data(bg_data), .bg_re(bg_re),
        .new_empty(new_empty), .new_data(new_data), .new_re(new_re),
        .mask_full(mask_full), .mask_we(mask_we), .mask_data(mask_data),
        .bgo_full(bgo_full), .bgo_we(bgo_we), .bgo_data(bgo_data),
        .frame_done(frame_done), .fg_count(fg_count)
    );

    int errors = 0;
    int checks = 0;

    logic [WW-1:0]    fifo_bg[$], fifo_new[$];
    bit               exp_fg[$];
    logic [WW-1:0]    exp_bgo[$];
    logic [PIX_W-1:0] obs_mask[$];
    logic [WW-1:0]    obs_bgo[$];
    int               pop_idx, push_idx, frame_fg, exp_fg_count, cyc;
    int               first_pop_cyc, first_push_cyc, last_fd_idx;
    logic [PIX_W+1:0] mthr;
    bit               last_pop, last_we;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] rep(input logic [PIX_W-1:0] v);
        return {CH{v}};
    endfunction

    // Reference: mask and background update from plain integer arithmetic.
    task automatic model_pop(input logic [WW-1:0] b, input logic [WW-1:0] n);
        int sum;
        bit any, fg;
        logic [WW-1:0] bo;
        if ((pop_idx % FP) == 0) mthr = cfg_thresh;
        pop_idx++;
        sum = 0; any = 1'b0; bo = '0;
        for (int c = 0; c < CH; c++) begin
            int bi, ni, d, ad, q;
            bi = int'(b[c*PIX_W +: PIX_W]);
            ni = int'(n[c*PIX_W +: PIX_W]);
            d  = ni - bi;
            ad = (d < 0) ? -d : d;
            sum += ad;
            if (ad > int'(mthr)) any = 1'b1;
            q  = (d >= 0) ? d / (1 << AS) : -((-d + (1 << AS) - 1) / (1 << AS));
            bo[c*PIX_W +: PIX_W] = PIX_W'(bi + q);
        end
        fg = cfg_mode ? (sum > int'(mthr)) : any;
        if (cfg_select && fg) bo = b;
        exp_fg.push_back(fg);
        exp_bgo.push_back(bo);
    endtask

    task automatic add_pix(input logic [WW-1:0] b, input logic [WW-1:0] n);
        fifo_bg.push_back(b);
        fifo_new.push_back(n);
    endtask

    // One clock: drive FIFO fronts, sample/check just after, then advance.
    task automatic cycle();
        bit ef, last, upd;
        logic [WW-1:0] eb;
        int next_fg;
        upd = 1'b0; next_fg = 0;
        bg_empty  = (fifo_bg.size() == 0);
        new_empty = (fifo_new.size() == 0);
        bg_data   = bg_empty ? '0 : fifo_bg[0];
        new_data  = new_empty ? '0 : fifo_new[0];
        #1;
        check("pop_pair", 32'(new_re), 32'(bg_re));
        check("pop_empty", 32'(bg_re & (bg_empty | new_empty)), 32'd0);
        check("we_blocked", 32'(mask_we & (mask_full | (cfg_bg_upd & bgo_full))), 32'd0);
        check("bgo_we", 32'(bgo_we), 32'(mask_we & cfg_bg_upd));
        check("fg_count", 32'(fg_count), 32'(exp_fg_count));
        if (mask_we) begin
            check("push_expected", 32'(exp_fg.size() > 0), 32'd1);
            if (exp_fg.size() > 0) begin
                ef = exp_fg.pop_front();
                eb = exp_bgo.pop_front();
                check("mask_data", 32'(mask_data), ef ? 32'hff : 32'h00);
                if (cfg_bg_upd) check("bgo_data", 32'(bgo_data), 32'(eb));
                last = ((push_idx % FP) == FP - 1);
                check("frame_done", 32'(frame_done), 32'(last));
                frame_fg += int'(ef);
                if (last) begin
                    next_fg = frame_fg; frame_fg = 0; upd = 1'b1;
                end
            end
            if (frame_done) last_fd_idx = push_idx;
            obs_mask.push_back(mask_data);
            obs_bgo.push_back(bgo_data);
            if (first_push_cyc < 0) first_push_cyc = cyc;
            push_idx++;
        end else begin
            check("frame_done_idle", 32'(frame_done), 32'd0);
        end
        last_pop = bg_re;
        last_we  = mask_we;
        if (bg_re && fifo_bg.size() > 0) begin
            model_pop(fifo_bg[0], fifo_new[0]);
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
        end
        @(posedge clk);
        if (last_pop && fifo_bg.size() > 0) begin
            void'(fifo_bg.pop_front());
            void'(fifo_new.pop_front());
        end
        if (upd) exp_fg_count = next_fg;
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        mask_full = 1'b0;
        bgo_full  = 1'b0;
        while ((fifo_bg.size() > 0 || exp_fg.size() > 0) && k < budget) begin
            cycle();
            k++;
        end
        check("drain_done", 32'(fifo_bg.size() + exp_fg.size()), 32'd0);
    endtask

    // Asserts reset at a negedge (asynchronously), checks outputs at once, clears model.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_bg_re", 32'(bg_re), 32'd0);
        check("rst_new_re", 32'(new_re), 32'd0);
        check("rst_mask_we", 32'(mask_we), 32'd0);
        check("rst_bgo_we", 32'(bgo_we), 32'd0);
        check("rst_mask_data", 32'(mask_data), 32'd0);
        check("rst_bgo_data", 32'(bgo_data), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_fg_count", 32'(fg_count), 32'd0);
        fifo_bg.delete(); fifo_new.delete(); exp_fg.delete(); exp_bgo.delete();
        obs_mask.delete(); obs_bgo.delete();
        pop_idx = 0; push_idx = 0; frame_fg = 0; exp_fg_count = 0; mthr = '0;
        first_pop_cyc = -1; first_push_cyc = -1; last_fd_idx = -1;
        bg_empty = 1'b1; new_empty = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int hold_pops;
        cyc = 0;
        @(negedge clk);

        // Grey-style data (equal channels), mode 0, threshold 50
        do_reset();
        cfg_mode = 1'b0; cfg_bg_upd = 1'b1; cfg_select = 1'b0; cfg_thresh = 10'd50;
        add_pix(rep(8'd100), rep(8'd151));
        add_pix(rep(8'd100), rep(8'd150));
        add_pix(rep(8'd200), rep(8'd149));
        drain(50);
        check("grey_cnt", 32'(obs_mask.size()), 32'd3);
        check("grey_m0", 32'(obs_mask[0]), 32'hff);
        check("grey_m1", 32'(obs_mask[1]), 32'h00);
        check("grey_m2", 32'(obs_mask[2]), 32'hff);
        check("latency", 32'(first_push_cyc - first_pop_cyc), 32'd2);

        // RGB, sum metric then any-channel metric, threshold 60
        do_reset();
        cfg_mode = 1'b1; cfg_thresh = 10'd60;
        add_pix(rep(8'd100), {8'd121, 8'd120, 8'd120});
        add_pix(rep(8'd100), rep(8'd120));
        drain(50);
        cfg_mode = 1'b0;
        add_pix(rep(8'd100), {8'd121, 8'd120, 8'd120});
        add_pix(rep(8'd100), rep(8'd120));
        drain(50);
        check("rgb_m1_a", 32'(obs_mask[0]), 32'hff);
        check("rgb_m1_b", 32'(obs_mask[1]), 32'h00);
        check("rgb_m0_a", 32'(obs_mask[2]), 32'h00);
        check("rgb_m0_b", 32'(obs_mask[3]), 32'h00);

        // Running average and selective update
        do_reset();
        cfg_mode = 1'b0; cfg_bg_upd = 1'b1; cfg_select = 1'b1; cfg_thresh = 10'd90;
        add_pix(rep(8'd100), rep(8'd180));
        add_pix(rep(8'd180), rep(8'd100));
        add_pix(rep(8'd180), rep(8'd20));
        drain(50);
        check("avg_up", 32'(obs_bgo[0]), 32'(rep(8'd110)));
        check("avg_down", 32'(obs_bgo[1]), 32'(rep(8'd170)));
        check("avg_select", 32'(obs_bgo[2]), 32'(rep(8'd180)));

        // Random data with random back-pressure and threshold churn
        do_reset();
        cfg_mode = 1'($urandom % 2); cfg_bg_upd = 1'b1; cfg_select = 1'($urandom % 2);
        cfg_thresh = 10'($urandom_range(20, 300));
        for (int i = 0; i < 80; i++) add_pix(WW'($urandom), WW'($urandom));
        for (int i = 0; i < 100; i++) begin
            if (i == 30) begin
                hold_pops = 0;
                bgo_full = 1'b0;
                for (int h = 0; h < 5; h++) begin
                    mask_full = 1'b1;
                    cycle();
                    if (h >= 2) hold_pops += int'(last_pop);
                end
                check("bp_pops_stop", 32'(hold_pops), 32'd0);
                mask_full = 1'b0; bgo_full = 1'b1;
                cycle();
                check("bgo_stall", 32'(last_we), 32'd0);
            end
            mask_full = (($urandom % 4) == 0);
            bgo_full  = (($urandom % 4) == 0);
            if (($urandom % 8) == 0) cfg_thresh = 10'($urandom_range(20, 300));
            cycle();
        end
        drain(400);
        check("rand_pushes", 32'(push_idx), 32'd80);

        // Frame boundary: 5 foreground pixels, threshold change mid-frame
        do_reset();
        cfg_mode = 1'b0; cfg_bg_upd = 1'b0; cfg_select = 1'b0; cfg_thresh = 10'd50;
        for (int i = 0; i < FP + 1; i++) begin
            if (i == 1 || i == 3 || i == 8 || i == 9 || i == 15 || i == FP)
                add_pix(rep(8'd100), rep(8'd200));
            else
                add_pix(rep(8'd100), rep(8'd120));
        end
        for (int k = 0; k < 100 && (fifo_bg.size() > 0 || exp_fg.size() > 0); k++) begin
            if (pop_idx >= 8) cfg_thresh = 10'd200;
            cycle();
        end
        check("frame_drained", 32'(push_idx), 32'(FP + 1));
        check("frame_fg5", 32'(fg_count), 32'd5);
        check("frame_done_idx", 32'(last_fd_idx), 32'(FP - 1));
        check("thr_ignored", 32'(obs_mask[8]), 32'hff);
        check("thr_next_frame", 32'(obs_mask[FP]), 32'h00);

        // Reset with both stages full: in-flight pixels dropped, frame restarts
        do_reset();
        cfg_mode = 1'b0; cfg_bg_upd = 1'b1; cfg_thresh = 10'd10;
        for (int i = 0; i < 6; i++) add_pix(rep(8'd100), rep(8'd200));
        for (int i = 0; i < 4; i++) begin
            mask_full = 1'b1;
            cycle();
        end
        check("pre_rst_stalled", 32'(last_we), 32'd0);
        cfg_thresh = 10'd250;
        do_reset();
        for (int i = 0; i < 4; i++) add_pix(rep(8'd100), rep(8'd200));
        drain(50);
        check("post_rst_cnt", 32'(obs_mask.size()), 32'd4);
        check("post_rst_thr", 32'(obs_mask[0]), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
